receiver_queue: RTL and testbench
=================================

Name: receiver_queue

Overview:
- Input buffer of a network node. Collects 32-bit instructions from three sources (right neighbour, left neighbour, self) and serialises them into one stream for the node's processing logic.
- Each source has its own FIFO. A fixed-priority arbiter pops at most one word per clock.
- Each popped word is presented with a one-cycle alert and a source tag.

Parameters:
- WIDTH, 32, instruction width in bits.
- DEPTH, 4, entries per source FIFO; power of two, minimum 2.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- check_r  in  1  enqueue strobe for in_sig_right, sampled each rising edge.
- check_l  in  1  enqueue strobe for in_sig_left.
- check_s  in  1  enqueue strobe for in_sig_self.
- in_sig_right  in  WIDTH  instruction from right neighbour.
- in_sig_left  in  WIDTH  instruction from left neighbour.
- in_sig_self  in  WIDTH  instruction from own node.
- selected_sig  out  WIDTH  instruction being delivered (registered).
- sig_alert  out  1  one-cycle pulse: selected_sig/s hold a new instruction.
- s  out  2  source tag: 01 right, 10 left, 11 self; 00 only after reset.

Behaviour:
- Reset (async assert, sync release): all FIFOs empty; selected_sig=0, sig_alert=0, s=00.
- Enqueue:
  - Every rising edge with check_x=1 writes the current in_sig_x into FIFO x.
  - The strobe is level-sampled: high for N edges enqueues N copies.
  - All three FIFOs may be written in the same cycle.
- Overflow: a push to a full FIFO is dropped silently. The FIFO contents are unchanged and there is no error output.
- A push and a pop on the same FIFO in the same cycle are both honoured, including when the FIFO is full (the pop frees a slot first).
- Arbitration is combinational over FIFO non-empty flags present before the edge. Fixed priority: right > left > self.
- Pop: at each rising edge, if any FIFO is non-empty:
  - pop the highest-priority one;
  - register its head word into selected_sig and its tag into s;
  - set sig_alert=1.
- If all FIFOs are empty at the edge, sig_alert=0 and selected_sig/s hold their previous values.
- Latency: a word captured at edge N into an empty system appears with sig_alert high after edge N+1, for exactly one cycle.
- Back-to-back delivery: a backlog drains one word per cycle with sig_alert continuously high, one cycle per word.
- Starvation: lower-priority sources wait while higher ones are non-empty. This is accepted by design.
- A word enqueued at edge N is never visible to the arbiter at edge N (no bypass path).
- Reset mid-operation discards all queued words immediately.

Decomposition:
- Shared package constants: WIDTH default; source tags SRC_NONE=2'b00, SRC_RIGHT=2'b01, SRC_LEFT=2'b10, SRC_SELF=2'b11.
- One sub-module, rq_fifo: single-clock FIFO with async reset.
  - Parameters WIDTH and DEPTH.
  - Signals push, pop, din, dout (head), empty, full.
  - Instantiated three times.
- The top level holds the arbiter and the output registers.

Test Plan:
- Reset then idle: sig_alert stays 0; selected_sig=0, s=00.
- check_r one cycle with right=42 → next cycle sig_alert=1, selected_sig=42, s=01. Following cycle sig_alert=0, selected_sig holds 42.
- check_l and check_s in the same cycle (left=73, self=89) → consecutive alerts: 73/s=10, then 89/s=11.
- check_l pulsed again with left still 73 → one alert, 73/s=10 (re-enqueue of a stale value).
- All three strobed in one cycle (right=500, left=800, self=4) → three consecutive alert cycles: 500/01, 800/10, 4/11, then sig_alert=0.
- Overflow: check_r held 6 cycles with right=1..6 while left/self are kept busy; after release, outputs show the ordering and drop behaviour required by DEPTH=4. Then assert reset mid-drain → outputs clear at once and no further alerts.

Source files
------------

// File: rtl/receiver_queue_pkg.sv
// ---------------------------------------------------------------------------
// receiver_queue_pkg : shared constants for the node receiver queue
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package receiver_queue_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 4;

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_RIGHT = 2'b01;
  localparam logic [1:0] SRC_LEFT  = 2'b10;
  localparam logic [1:0] SRC_SELF  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/rq_fifo.sv
// ---------------------------------------------------------------------------
// rq_fifo : single-clock FIFO with async reset and combinational head word
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/receiver_queue.sv
// ---------------------------------------------------------------------------
// receiver_queue : three per-source FIFOs merged by a fixed-priority arbiter
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module receiver_queue
  import receiver_queue_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             check_r,
  input  logic             check_l,
  input  logic             check_s,
  input  logic [WIDTH-1:0] in_sig_right,
  input  logic [WIDTH-1:0] in_sig_left,
  input  logic [WIDTH-1:0] in_sig_self,
  output logic [WIDTH-1:0] selected_sig,
  output logic             sig_alert,
  output logic [1:0]       s
);

  logic [WIDTH-1:0] w_dout_r, w_dout_l, w_dout_s;
  logic             w_empty_r, w_empty_l, w_empty_s;
  logic             w_full_r, w_full_l, w_full_s;
  logic             w_pop_r, w_pop_l, w_pop_s;
  logic             w_any;
  logic [WIDTH-1:0] w_data;
  logic [1:0]       w_tag;

  logic [WIDTH-1:0] r_selected;
  logic             r_alert;
  logic [1:0]       r_src;

  rq_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_r (
    .clk(clk), .rst(reset), .push(check_r), .pop(w_pop_r), .din(in_sig_right),
    .dout(w_dout_r), .empty(w_empty_r), .full(w_full_r)
  );

  rq_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_l (
    .clk(clk), .rst(reset), .push(check_l), .pop(w_pop_l), .din(in_sig_left),
    .dout(w_dout_l), .empty(w_empty_l), .full(w_full_l)
  );

  rq_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_s (
    .clk(clk), .rst(reset), .push(check_s), .pop(w_pop_s), .din(in_sig_self),
    .dout(w_dout_s), .empty(w_empty_s), .full(w_full_s)
  );

  // Full flags are not needed here: the FIFOs drop overflowing pushes themselves.
  logic w_unused_full;
  assign w_unused_full = w_full_r ^ w_full_l ^ w_full_s;

  // Fixed priority right > left > self on pre-edge occupancy only.
  always_comb begin
    w_pop_r = 1'b0;
    w_pop_l = 1'b0;
    w_pop_s = 1'b0;
    w_any   = 1'b1;
    w_data  = '0;
    w_tag   = SRC_NONE;
    if (!w_empty_r) begin
      w_pop_r = 1'b1;
      w_data  = w_dout_r;
      w_tag   = SRC_RIGHT;
    end else if (!w_empty_l) begin
      w_pop_l = 1'b1;
      w_data  = w_dout_l;
      w_tag   = SRC_LEFT;
    end else if (!w_empty_s) begin
      w_pop_s = 1'b1;
      w_data  = w_dout_s;
      w_tag   = SRC_SELF;
    end else begin
      w_any   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_selected <= '0;
      r_alert    <= 1'b0;
      r_src      <= SRC_NONE;
    end else begin
      r_alert <= w_any;
      if (w_any) begin
        r_selected <= w_data;
        r_src      <= w_tag;
      end
    end
  end

  assign selected_sig = r_selected;
  assign sig_alert    = r_alert;
  assign s            = r_src;

endmodule

`default_nettype wire

// File: tb/tb_receiver_queue.sv
// ---------------------------------------------------------------------------
// tb_receiver_queue : scoreboard bench with per-source queue reference model
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_receiver_queue;

  localparam int W = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          check_r, check_l, check_s;
  logic [W-1:0]  in_sig_right, in_sig_left, in_sig_self;
  logic [W-1:0]  selected_sig;
  logic          sig_alert;
  logic [1:0]    s;

  receiver_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .check_r(check_r), .check_l(check_l), .check_s(check_s),
    .in_sig_right(in_sig_right), .in_sig_left(in_sig_left), .in_sig_self(in_sig_self),
    .selected_sig(selected_sig), .sig_alert(sig_alert), .s(s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   t;
  } exp_t;

  logic [W-1:0] qr[$];
  logic [W-1:0] ql[$];
  logic [W-1:0] qs[$];
  exp_t         exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: whole-word queues; each edge delivers the head of the
  // highest-priority non-empty queue, then accepts new words if room remains.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qr.delete(); ql.delete(); qs.delete(); exp_q.delete();
    end else begin
      exp_t e;
      if (qr.size() > 0) begin
        e.d = qr.pop_front(); e.t = 2'b01; exp_q.push_back(e);
      end else if (ql.size() > 0) begin
        e.d = ql.pop_front(); e.t = 2'b10; exp_q.push_back(e);
      end else if (qs.size() > 0) begin
        e.d = qs.pop_front(); e.t = 2'b11; exp_q.push_back(e);
      end
      if (check_r && qr.size() < D) qr.push_back(in_sig_right);
      if (check_l && ql.size() < D) ql.push_back(in_sig_left);
      if (check_s && qs.size() < D) qs.push_back(in_sig_self);
    end
  end

  logic [W-1:0] hold_d = '0;
  logic [1:0]   hold_t = 2'b00;

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_alert", {31'd0, sig_alert}, 32'd0);
      chk("reset_data", selected_sig, 32'd0);
      chk("reset_tag", {30'd0, s}, 32'd0);
      hold_d = '0;
      hold_t = 2'b00;
    end else if (sig_alert) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_alert", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data", selected_sig, e.d);
        chk("tag", {30'd0, s}, {30'd0, e.t});
        hold_d = e.d;
        hold_t = e.t;
      end
    end else begin
      chk("missing_alert", exp_q.size(), 32'd0);
      chk("hold_data", selected_sig, hold_d);
      chk("hold_tag", {30'd0, s}, {30'd0, hold_t});
    end
  end

  task automatic drive(input logic r, input logic l, input logic sf,
                       input logic [W-1:0] dr, input logic [W-1:0] dl, input logic [W-1:0] ds);
    @(negedge clk);
    check_r = r; check_l = l; check_s = sf;
    in_sig_right = dr; in_sig_left = dl; in_sig_self = ds;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, in_sig_right, in_sig_left, in_sig_self);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    check_r = 1'b0; check_l = 1'b0; check_s = 1'b0;
    in_sig_right = '0; in_sig_left = '0; in_sig_self = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(4);

    drive(1, 0, 0, 32'd42, 0, 0);
    idle(3);
    drive(0, 1, 1, 32'd42, 32'd73, 32'd89);
    idle(4);
    drive(0, 1, 0, 32'd42, 32'd73, 32'd89);
    idle(3);
    drive(1, 1, 1, 32'd500, 32'd800, 32'd4);
    idle(5);

    // Right streams for six edges while left/self pile up past their depth.
    for (int i = 1; i <= 6; i++) drive(1, 1, 1, i, 100 + i, 200 + i);
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_alert", {31'd0, sig_alert}, 32'd0);
    chk("async_reset_data", selected_sig, 32'd0);
    chk("async_reset_tag", {30'd0, s}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(4);

    for (int i = 0; i < 150; i++)
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom, $urandom, $urandom);
    for (int i = 0; i < 150; i++)
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
            $urandom, $urandom, $urandom);
    drive(0, 0, 0, 0, 0, 0);

    begin
      int budget = 40;
      while ((qr.size() + ql.size() + qs.size() + exp_q.size()) != 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      chk("drain_complete", qr.size() + ql.size() + qs.size() + exp_q.size(), 32'd0);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
